// File: rtl/nna_pkg.sv
// Shared types and helpers for the batch-inference sequencer and its argmax engine.
package nna_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INFER,
    S_ARGMAX,
    S_DONE
  } state_t;

  // Sliced down to the label width at the point of use.
  localparam logic [31:0] PRED_NONE = '1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nna_argmax_seq.sv
// Sequential argmax over a snapshot of signed activations, one class per cycle.
module nna_argmax_seq
  import nna_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int ACT_W       = 16,
  parameter int IDX_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_CLASSES*ACT_W-1:0] act,
  output logic                         done,
  output logic [IDX_W-1:0]             max_index
);

  localparam int CW = idx_w(NUM_CLASSES);

  logic [NUM_CLASSES-1:0][ACT_W-1:0] act_q;
  logic signed [ACT_W-1:0]           best;
  logic signed [ACT_W-1:0]           cand;
  logic [CW-1:0]                     idx;
  logic [CW-1:0]                     best_idx;
  logic                              running;
  logic                              take;

  assign cand = act_q[idx];
  // Strictly greater, so ties keep the lower index.
  assign take = cand > best;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q     <= '0;
      best      <= '0;
      best_idx  <= '0;
      idx       <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      max_index <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        act_q    <= act;
        best     <= $signed(act[ACT_W-1:0]);
        best_idx <= '0;
        idx      <= CW'(1);
        running  <= 1'b1;
      end else if (running) begin
        if (take) begin
          best     <= cand;
          best_idx <= idx;
        end
        if (idx == CW'(NUM_CLASSES - 1)) begin
          running   <= 1'b0;
          done      <= 1'b1;
          max_index <= IDX_W'(take ? idx : best_idx);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nna_batch_sequencer.sv
// Batch-inference controller: streams pixels in, kicks the accelerator, argmaxes the
// activations and tallies predictions against labels across a batch.
module nna_batch_sequencer
  import nna_pkg::*;
#(
  parameter int NUM_INPUTS  = 256,
  parameter int IN_W        = 8,
  parameter int NUM_CLASSES = 10,
  parameter int ACT_W       = 16,
  parameter int LABEL_W     = 4,
  parameter int CNT_W       = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [CNT_W-1:0]             batch_size,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_W-1:0]              in_data,
  input  logic [LABEL_W-1:0]           in_label,
  output logic [NUM_INPUTS*IN_W-1:0]   accel_inputs,
  output logic                         accel_start,
  input  logic                         accel_done,
  input  logic [NUM_CLASSES*ACT_W-1:0] accel_act,
  output logic [LABEL_W-1:0]           pred,
  output logic                         pred_valid,
  output logic [CNT_W-1:0]             sample_cnt,
  output logic [CNT_W-1:0]             correct_cnt,
  output logic                         busy,
  output logic                         batch_done
);

  localparam int                 PIX_W    = idx_w(NUM_INPUTS);
  localparam logic [PIX_W-1:0]   PIX_LAST = PIX_W'(NUM_INPUTS - 1);
  localparam logic [LABEL_W-1:0] NO_PRED  = PRED_NONE[LABEL_W-1:0];

  state_t                         state;
  logic [NUM_INPUTS-1:0][IN_W-1:0] buf_q;
  logic [PIX_W-1:0]               pix_idx;
  logic [LABEL_W-1:0]             label_q;
  logic [CNT_W-1:0]               batch_q;
  logic [CNT_W-1:0]               sample_nxt;
  logic                           done_q;
  logic                           done_edge;
  logic                           am_go;
  logic                           am_done;
  logic [LABEL_W-1:0]             am_idx;
  logic                           hit;

  assign accel_inputs = buf_q;
  assign in_ready     = (state == S_LOAD);
  assign accel_start  = (state == S_INFER);
  assign busy         = (state == S_LOAD) || (state == S_INFER) || (state == S_ARGMAX);
  assign batch_done   = (state == S_DONE);

  // A level already high when INFER is entered is stale; only a fresh rise counts.
  assign done_edge  = accel_done && !done_q;
  assign sample_nxt = sample_cnt + 1'b1;
  assign hit        = (am_idx == label_q) && (label_q < LABEL_W'(NUM_CLASSES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= accel_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      buf_q       <= '0;
      pix_idx     <= '0;
      label_q     <= '0;
      batch_q     <= '0;
      am_go       <= 1'b0;
      pred        <= NO_PRED;
      pred_valid  <= 1'b0;
      sample_cnt  <= '0;
      correct_cnt <= '0;
    end else begin
      pred_valid <= 1'b0;
      am_go      <= 1'b0;
      if (abort) begin
        state   <= S_IDLE;
        pix_idx <= '0;
        pred    <= NO_PRED;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              sample_cnt  <= '0;
              correct_cnt <= '0;
              pred        <= NO_PRED;
              pix_idx     <= '0;
              batch_q     <= batch_size;
              state       <= (batch_size == '0) ? S_DONE : S_LOAD;
            end
          end
          S_LOAD: begin
            if (in_valid) begin
              buf_q[pix_idx] <= in_data;
              if (pix_idx == PIX_LAST) begin
                label_q <= in_label;
                pix_idx <= '0;
                state   <= S_INFER;
              end else begin
                pix_idx <= pix_idx + 1'b1;
              end
            end
          end
          S_INFER: begin
            if (done_edge) begin
              am_go <= 1'b1;
              state <= S_ARGMAX;
            end
          end
          S_ARGMAX: begin
            if (am_done) begin
              pred       <= am_idx;
              pred_valid <= 1'b1;
              sample_cnt <= sample_nxt;
              if (hit) correct_cnt <= correct_cnt + 1'b1;
              state <= (sample_nxt == batch_q) ? S_DONE : S_LOAD;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  nna_argmax_seq #(
    .NUM_CLASSES (NUM_CLASSES),
    .ACT_W       (ACT_W),
    .IDX_W       (LABEL_W)
  ) u_argmax (
    .clk       (clk),
    .rst       (rst),
    .start     (am_go),
    .act       (accel_act),
    .done      (am_done),
    .max_index (am_idx)
  );

endmodule
